// File: rtl/pb_timer_irq_pkg.sv
// pb_timer_irq_pkg: register offsets, bit indices and irq FSM states for pb_timer_irq
package pb_timer_irq_pkg;
  localparam logic [2:0] OFF_CTRL      = 3'd0;
  localparam logic [2:0] OFF_RELOAD_LO = 3'd1;
  localparam logic [2:0] OFF_RELOAD_HI = 3'd2;
  localparam logic [2:0] OFF_STATUS    = 3'd3;
  localparam logic [2:0] OFF_COUNT_LO  = 3'd4;
  localparam logic [2:0] OFF_COUNT_HI  = 3'd5;
  localparam int CTRL_EN       = 0;
  localparam int CTRL_AUTO     = 1;
  localparam int CTRL_IRQ_EN   = 2;
  localparam int STAT_EXP      = 0;
  localparam int STAT_IRQ_PEND = 1;
  typedef enum logic [1:0] {
    IRQ_IDLE   = 2'd0,
    IRQ_ASSERT = 2'd1,
    IRQ_GAP    = 2'd2
  } irq_state_e;
endpackage

// File: rtl/pb_irq_handshake.sv
// pb_irq_handshake: interrupt request/acknowledge FSM with a one-deep queued expire
module pb_irq_handshake
  import pb_timer_irq_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic expire,
  input  logic irq_en,
  input  logic interrupt_ack,
  output logic interrupt,
  output logic irq_pend
);
  irq_state_e state_q, state_d;
  logic pend_q, pend_d;
  logic ev;
  always_comb begin
    ev = expire && irq_en;
    state_d = state_q;
    pend_d = pend_q;
    case (state_q)
      IRQ_IDLE: state_d = ev ? IRQ_ASSERT : IRQ_IDLE;
      IRQ_ASSERT: begin
        state_d = interrupt_ack ? ((pend_q || ev) ? IRQ_GAP : IRQ_IDLE) : IRQ_ASSERT;
        pend_d = !interrupt_ack && (pend_q || ev);
      end
      IRQ_GAP: begin
        state_d = IRQ_ASSERT;
        pend_d = pend_q || ev;
      end
      default: begin
        state_d = IRQ_IDLE;
        pend_d = 1'b0;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IRQ_IDLE;
      pend_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q <= pend_d;
    end
  end
  assign interrupt = (state_q == IRQ_ASSERT);
  assign irq_pend = (state_q != IRQ_IDLE) || pend_q;
endmodule

// File: rtl/pb_timer_irq.sv
// pb_timer_irq: PicoBlaze port-mapped prescaled down-counter timer with interrupt
module pb_timer_irq
  import pb_timer_irq_pkg::*;
#(
  parameter logic [7:0] BASE_ADDR = 8'h10,
  parameter int PRESCALE = 100
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] port_id,
  input  logic [7:0] out_port,
  input  logic       write_strobe,
  input  logic       read_strobe,
  output logic [7:0] in_port,
  output logic       interrupt,
  input  logic       interrupt_ack
);
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(PRESCALE - 1);
  logic [2:0] ctrl_q, ctrl_d;
  logic [15:0] reload_q, reload_d, count_q, count_d;
  logic [PW-1:0] presc_q, presc_d;
  logic exp_q, exp_d;
  logic [7:0] shadow_q, shadow_d, in_port_q, in_port_d, rdata;
  logic sel, wr, rd, tick, expire, irq_pend;
  logic [2:0] off;
  always_comb begin
    sel = (port_id[7:3] == BASE_ADDR[7:3]);
    off = port_id[2:0];
    wr = write_strobe && sel;
    rd = read_strobe && sel;
    tick = ctrl_q[CTRL_EN] && (presc_q == '0);
    expire = tick && (count_q == '0);
    presc_d = !ctrl_q[CTRL_EN] ? presc_q : tick ? PRE_MAX : presc_q - 1'b1;
    count_d = !tick ? count_q : (count_q != '0) ? count_q - 16'd1 :
              ctrl_q[CTRL_AUTO] ? reload_q : count_q;
    ctrl_d = ctrl_q;
    ctrl_d[CTRL_EN] = ctrl_q[CTRL_EN] && !(expire && !ctrl_q[CTRL_AUTO]);
    // A CTRL write overrides the counter's own EN clear; a 0->1 EN edge restarts the period
    if (wr && off == OFF_CTRL) begin
      ctrl_d = out_port[2:0];
      if (out_port[CTRL_EN] && !ctrl_q[CTRL_EN]) begin
        count_d = reload_q;
        presc_d = PRE_MAX;
      end
    end
    reload_d[7:0] = (wr && off == OFF_RELOAD_LO) ? out_port : reload_q[7:0];
    reload_d[15:8] = (wr && off == OFF_RELOAD_HI) ? out_port : reload_q[15:8];
    exp_d = expire || (exp_q && !(wr && off == OFF_STATUS && out_port[STAT_EXP]));
    shadow_d = (rd && off == OFF_COUNT_LO) ? count_q[15:8] : shadow_q;
    case (off)
      OFF_CTRL:      rdata = {5'd0, ctrl_q};
      OFF_RELOAD_LO: rdata = reload_q[7:0];
      OFF_RELOAD_HI: rdata = reload_q[15:8];
      OFF_STATUS:    rdata = {6'd0, irq_pend, exp_q};
      OFF_COUNT_LO:  rdata = count_q[7:0];
      OFF_COUNT_HI:  rdata = shadow_q;
      default:       rdata = 8'd0;
    endcase
    in_port_d = sel ? rdata : 8'd0;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_q <= '0;
      reload_q <= 16'hFFFF;
      count_q <= '0;
      presc_q <= '0;
      exp_q <= 1'b0;
      shadow_q <= '0;
      in_port_q <= '0;
    end else begin
      ctrl_q <= ctrl_d;
      reload_q <= reload_d;
      count_q <= count_d;
      presc_q <= presc_d;
      exp_q <= exp_d;
      shadow_q <= shadow_d;
      in_port_q <= in_port_d;
    end
  end
  pb_irq_handshake u_irq (
    .clk(clk),
    .rst(reset),
    .expire(expire),
    .irq_en(ctrl_q[CTRL_IRQ_EN]),
    .interrupt_ack(interrupt_ack),
    .interrupt(interrupt),
    .irq_pend(irq_pend)
  );
  assign in_port = in_port_q;
endmodule

// File: tb/tb_pb_timer_irq.sv
// tb_pb_timer_irq: directed checks of pb_timer_irq with PRESCALE=4, BASE_ADDR=8'h10
module tb_pb_timer_irq;
  logic clk = 1'b0;
  logic reset, write_strobe, read_strobe, interrupt, interrupt_ack;
  logic [7:0] port_id, out_port, in_port;
  int checks = 0;
  int failures = 0;
  always #5 clk = ~clk;
  pb_timer_irq #(.BASE_ADDR(8'h10), .PRESCALE(4)) dut (
    .clk(clk),
    .reset(reset),
    .port_id(port_id),
    .out_port(out_port),
    .write_strobe(write_strobe),
    .read_strobe(read_strobe),
    .in_port(in_port),
    .interrupt(interrupt),
    .interrupt_ack(interrupt_ack)
  );
  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic wr_reg(input logic [7:0] a, input logic [7:0] d);
    port_id = a;
    out_port = d;
    write_strobe = 1'b1;
    step(1);
    write_strobe = 1'b0;
  endtask
  task automatic rd_chk(input string tag, input logic [7:0] a, input logic [7:0] exp);
    port_id = a;
    read_strobe = 1'b1;
    step(1);
    read_strobe = 1'b0;
    chk(tag, {8'd0, in_port}, {8'd0, exp});
  endtask
  task automatic ack();
    interrupt_ack = 1'b1;
    step(1);
    interrupt_ack = 1'b0;
  endtask
  task automatic chk_reset_regs(input string tag);
    logic [7:0] exp_tbl [8] = '{8'h00, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    for (int i = 0; i < 8; i++) rd_chk($sformatf("%s_p%0d", tag, i), 8'h10 + 8'(i), exp_tbl[i]);
  endtask
  initial begin
    reset = 1'b1;
    write_strobe = 1'b0;
    read_strobe = 1'b0;
    interrupt_ack = 1'b0;
    port_id = 8'h00;
    out_port = 8'h00;
    step(2);
    reset = 1'b0;
    chk("rst_irq", {15'd0, interrupt}, 16'd0);
    chk("rst_inport", {8'd0, in_port}, 16'd0);
    chk_reset_regs("rst");
    rd_chk("unsel", 8'h22, 8'h00);
    // periodic: RELOAD=3 -> expire every 16 clocks
    wr_reg(8'h11, 8'h03);
    wr_reg(8'h12, 8'h00);
    wr_reg(8'h10, 8'h07);
    step(15);
    chk("per_pre1", {15'd0, interrupt}, 16'd0);
    step(1);
    chk("per_rise1", {15'd0, interrupt}, 16'd1);
    ack();
    chk("per_ack1", {15'd0, interrupt}, 16'd0);
    step(14);
    chk("per_pre2", {15'd0, interrupt}, 16'd0);
    step(1);
    chk("per_rise2", {15'd0, interrupt}, 16'd1);
    ack();
    chk("per_ack2", {15'd0, interrupt}, 16'd0);
    wr_reg(8'h10, 8'h00);
    wr_reg(8'h13, 8'h01);
    rd_chk("stat_clr", 8'h13, 8'h00);
    ack();
    chk("idle_ack", {15'd0, interrupt}, 16'd0);
    // one-shot: RELOAD=0
    wr_reg(8'h11, 8'h00);
    wr_reg(8'h12, 8'h00);
    wr_reg(8'h10, 8'h05);
    step(3);
    chk("os_pre", {15'd0, interrupt}, 16'd0);
    step(1);
    chk("os_rise", {15'd0, interrupt}, 16'd1);
    rd_chk("os_ctrl", 8'h10, 8'h04);
    rd_chk("os_stat", 8'h13, 8'h03);
    rd_chk("os_cnt", 8'h14, 8'h00);
    ack();
    chk("os_ack", {15'd0, interrupt}, 16'd0);
    wr_reg(8'h13, 8'h01);
    rd_chk("os_stat_clr", 8'h13, 8'h00);
    // merged: three expires before ack, then timer stopped
    wr_reg(8'h10, 8'h07);
    step(4);
    chk("mg_rise", {15'd0, interrupt}, 16'd1);
    step(4);
    chk("mg_hold1", {15'd0, interrupt}, 16'd1);
    step(4);
    chk("mg_hold2", {15'd0, interrupt}, 16'd1);
    wr_reg(8'h10, 8'h04);
    chk("mg_hold3", {15'd0, interrupt}, 16'd1);
    ack();
    chk("mg_gap", {15'd0, interrupt}, 16'd0);
    step(1);
    chk("mg_reassert", {15'd0, interrupt}, 16'd1);
    ack();
    chk("mg_ack2", {15'd0, interrupt}, 16'd0);
    step(2);
    chk("mg_idle", {15'd0, interrupt}, 16'd0);
    rd_chk("mg_stat", 8'h13, 8'h01);
    // shadowed 16-bit count read
    wr_reg(8'h10, 8'h00);
    wr_reg(8'h11, 8'h34);
    wr_reg(8'h12, 8'h12);
    wr_reg(8'h10, 8'h03);
    step(8);
    rd_chk("cnt_lo", 8'h14, 8'h32);
    rd_chk("cnt_hi", 8'h15, 8'h12);
    // reset mid-count with interrupt high
    wr_reg(8'h10, 8'h00);
    wr_reg(8'h11, 8'h03);
    wr_reg(8'h12, 8'h00);
    wr_reg(8'h10, 8'h07);
    step(16);
    chk("pre_rst_irq", {15'd0, interrupt}, 16'd1);
    step(5);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    chk("mid_rst_irq", {15'd0, interrupt}, 16'd0);
    chk_reset_regs("mid_rst");
    // STATUS clear colliding with an expire: expire wins
    wr_reg(8'h11, 8'h00);
    wr_reg(8'h12, 8'h00);
    wr_reg(8'h10, 8'h01);
    step(3);
    wr_reg(8'h13, 8'h01);
    rd_chk("col_stat", 8'h13, 8'h01);
    rd_chk("col_ctrl", 8'h10, 8'h00);
    wr_reg(8'h13, 8'h01);
    rd_chk("col_clr", 8'h13, 8'h00);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
